// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BHT/BTB predictor with execute-stage resolution and perf counters
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_alu_result,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic [31:0]      pc_four,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] stat_resolved,
  output logic [CNT_W-1:0] stat_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int TW    = (TAG_W > 0) ? TAG_W : 1;

  logic             r_valid [ENTRIES];
  logic [TW-1:0]    r_tag   [ENTRIES];
  logic [1:0]       r_cnt   [ENTRIES];
  logic [PC_W-1:0]  r_tgt   [ENTRIES];
  logic [CNT_W-1:0] r_res, r_mis;

  // a zero-width tag is stored as one don't-care bit and always matches
  function automatic logic [TW-1:0] tag_of(input logic [PC_W-1:0] pc);
    logic [PC_W-1:0] s;
    s = pc >> (IDX_W + 2);
    return s[TW-1:0];
  endfunction

  logic [IDX_W-1:0] w_if_idx, w_ex_idx;
  logic [TW-1:0]    w_if_tag, w_ex_tag;
  logic             w_ex_hit, w_ctrl, w_act_taken;
  logic [31:0]      w_act_tgt;

  assign w_if_idx    = if_pc[IDX_W+1:2];
  assign w_ex_idx    = ex_pc[IDX_W+1:2];
  assign w_if_tag    = tag_of(if_pc);
  assign w_ex_tag    = tag_of(ex_pc);
  assign pred_taken  = r_valid[w_if_idx] && ((TAG_W == 0) || (r_tag[w_if_idx] == w_if_tag)) && r_cnt[w_if_idx][1];
  assign pred_target = pred_taken ? 32'(r_tgt[w_if_idx]) : 32'd0;

  assign w_ex_hit    = r_valid[w_ex_idx] && ((TAG_W == 0) || (r_tag[w_ex_idx] == w_ex_tag));
  assign w_ctrl      = ex_branch | ex_jal | ex_jalr;
  assign w_act_taken = ex_jal | ex_jalr | (ex_branch && (ex_alu_result != 32'd0));
  assign pc_four     = 32'(ex_pc) + 32'd4;
  assign w_act_tgt   = ex_jalr ? {ex_alu_result[31:1], 1'b0} : 32'(ex_pc) + ex_imm;
  assign mispredict  = ex_valid && (w_ctrl || ex_pred_taken) &&
                       ((ex_pred_taken != w_act_taken) ||
                        (ex_pred_taken && w_act_taken && (ex_pred_target != w_act_tgt)));
  assign redirect_pc = w_act_taken ? w_act_tgt : pc_four;

  assign stat_resolved = r_res;
  assign stat_mispred  = r_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_cnt[i]   <= 2'b01;
        r_tgt[i]   <= '0;
      end
      r_res <= '0;
      r_mis <= '0;
    end else begin
      if (ex_valid && w_ctrl) begin
        r_valid[w_ex_idx] <= 1'b1;
        r_tag[w_ex_idx]   <= w_ex_tag;
        if (w_act_taken) r_tgt[w_ex_idx] <= w_act_tgt[PC_W-1:0];
        r_cnt[w_ex_idx]   <= !w_ex_hit ? (w_act_taken ? 2'd2 : 2'd1) :
                             w_act_taken ? ((r_cnt[w_ex_idx] == 2'd3) ? 2'd3 : r_cnt[w_ex_idx] + 2'd1) :
                                           ((r_cnt[w_ex_idx] == 2'd0) ? 2'd0 : r_cnt[w_ex_idx] - 2'd1);
      end else if (ex_valid && ex_pred_taken) begin
        r_valid[w_ex_idx] <= 1'b0;
      end
      if (stat_clear) begin
        r_res <= '0;
        r_mis <= '0;
      end else begin
        if (ex_valid && w_ctrl && !(&r_res)) r_res <= r_res + 1'b1;
        if (mispredict && !(&r_mis)) r_mis <= r_mis + 1'b1;
      end
    end
  end
endmodule
